irq_ctrl: RTL and testbench

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl_pkg.sv | 26 ++
 rtl/irq_prio_enc.sv | 25 ++
 rtl/irq_ctrl.sv | 112 +++++++++++
 tb/tb_irq_ctrl.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, source
// indices, interrupt width and the ID word layout.
package irq_ctrl_pkg;

    localparam int IRQ_W = 6;

    typedef enum logic [1:0] {
        REG_PEND = 2'd0,
        REG_MASK = 2'd1,
        REG_MODE = 2'd2,
        REG_ID   = 2'd3
    } reg_sel_e;

    localparam int SRC_TC0 = 0;
    localparam int SRC_TC1 = 1;
    localparam int SRC_EXT = 2;

    localparam logic [IRQ_W-1:0] MASK_RST = 6'h3F;
    localparam logic [IRQ_W-1:0] MODE_RST = 6'h00;

    // ID word: valid flag at bit 6, winning index in [2:0].
    function automatic logic [31:0] id_word(input logic valid, input logic [2:0] idx);
        return {25'b0, valid, 3'b0, idx};
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: lowest set request index wins.
module irq_prio_enc
    import irq_ctrl_pkg::*;
(
    input  logic [IRQ_W-1:0] req,
    output logic             valid,
    output logic [2:0]       idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        valid = 1'b0;
        idx   = 3'd0;
        for (int i = IRQ_W - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = 3'(i);
            end else begin
                valid = valid;
                idx   = idx;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source edge/level pending latch, mask, ID
// priority read-out and CPU acknowledge, with HWInt registered.
module irq_ctrl
    import irq_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [IRQ_W-1:0] irq_src,
    input  logic [31:0]      Addr,
    input  logic             WE,
    input  logic [31:0]      Din,
    output logic [31:0]      Dout,
    input  logic             int_ack,
    output logic [IRQ_W-1:0] HWInt,
    output logic             irq_any
);

    logic [IRQ_W-1:0] prev_r;
    logic [IRQ_W-1:0] pend_r;
    logic [IRQ_W-1:0] mask_r;
    logic [IRQ_W-1:0] mode_r;
    logic [IRQ_W-1:0] hwint_r;
    logic             irq_any_r;

    reg_sel_e         sel_s;
    logic [IRQ_W-1:0] rise_s;
    logic [IRQ_W-1:0] w1c_s;
    logic [IRQ_W-1:0] ack_s;
    logic [IRQ_W-1:0] edge_next_s;
    logic [IRQ_W-1:0] pend_next_s;
    logic [IRQ_W-1:0] mask_next_s;
    logic [IRQ_W-1:0] mode_next_s;
    logic             id_valid_s;
    logic [2:0]       id_idx_s;

    logic             unused_bits_s;
    assign unused_bits_s = &{1'b0, Addr[31:4], Addr[1:0], Din[31:6]};

    irq_prio_enc u_prio_enc (
        .req   (pend_r & mask_r),
        .valid (id_valid_s),
        .idx   (id_idx_s)
    );

    // Next-state of pend/mask/mode; a new edge overrides any clear in the same cycle.
    always_comb begin
        sel_s  = reg_sel_e'(Addr[3:2]);
        rise_s = irq_src & ~prev_r;

        if (WE && (sel_s == REG_PEND)) begin
            w1c_s = Din[IRQ_W-1:0];
        end else begin
            w1c_s = 6'h00;
        end

        if (int_ack && id_valid_s) begin
            ack_s = 6'(6'h01 << id_idx_s);
        end else begin
            ack_s = 6'h00;
        end

        edge_next_s = rise_s | (pend_r & ~(w1c_s | ack_s));
        pend_next_s = (mode_r & edge_next_s) | (~mode_r & irq_src);

        if (WE && (sel_s == REG_MASK)) begin
            mask_next_s = Din[IRQ_W-1:0];
        end else begin
            mask_next_s = mask_r;
        end

        if (WE && (sel_s == REG_MODE)) begin
            mode_next_s = Din[IRQ_W-1:0];
        end else begin
            mode_next_s = mode_r;
        end
    end

    // State registers; HWInt is built from the values being loaded this edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_r    <= 6'h00;
            pend_r    <= 6'h00;
            mask_r    <= MASK_RST;
            mode_r    <= MODE_RST;
            hwint_r   <= 6'h00;
            irq_any_r <= 1'b0;
        end else begin
            prev_r    <= irq_src;
            pend_r    <= pend_next_s;
            mask_r    <= mask_next_s;
            mode_r    <= mode_next_s;
            hwint_r   <= pend_next_s & mask_next_s;
            irq_any_r <= |(pend_next_s & mask_next_s);
        end
    end

    // Register read mux, zero-extended.
    always_comb begin
        Dout = 32'h0000_0000;
        case (sel_s)
            REG_PEND: Dout = {26'b0, pend_r};
            REG_MASK: Dout = {26'b0, mask_r};
            REG_MODE: Dout = {26'b0, mode_r};
            REG_ID:   Dout = id_word(id_valid_s, id_idx_s);
            default:  Dout = 32'h0000_0000;
        endcase
    end

    assign HWInt   = hwint_r;
    assign irq_any = irq_any_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// Table-driven directed bench for irq_ctrl with hand-written reset sequences.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic [5:0]  irq_src;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        int_ack;
    logic [5:0]  HWInt;
    logic        irq_any;

    int n_checks;
    int n_fails;

    typedef struct {
        logic [5:0]  src;
        logic        we;
        logic [1:0]  wa;
        logic [31:0] din;
        logic        ack;
        logic [1:0]  ra;
        logic [31:0] exp_dout;
        logic [5:0]  exp_hw;
    } vec_t;

    localparam int NV = 35;
    vec_t tbl [NV];

    irq_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .irq_src (irq_src),
        .Addr    (Addr),
        .WE      (WE),
        .Din     (Din),
        .Dout    (Dout),
        .int_ack (int_ack),
        .HWInt   (HWInt),
        .irq_any (irq_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [31:0] exp_dout, input logic [5:0] exp_hw);
        check32({tag, " Dout"}, Dout, exp_dout);
        check32({tag, " HWInt"}, {26'b0, HWInt}, {26'b0, exp_hw});
        check32({tag, " irq_any"}, {31'b0, irq_any}, {31'b0, |exp_hw});
    endtask

    task automatic run_vec(input int i, input vec_t v);
        irq_src = v.src;
        WE      = v.we;
        Addr    = {28'h0, v.wa, 2'b00};
        Din     = v.din;
        int_ack = v.ack;
        @(posedge clk);
        #1;
        WE      = 1'b0;
        int_ack = 1'b0;
        Din     = 32'h0;
        Addr    = {28'h0, v.ra, 2'b00};
        #1;
        check_outs($sformatf("vec%0d", i), v.exp_dout, v.exp_hw);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        //          src    we    wa    din           ack   ra    dout          hw
        tbl[0]  = '{6'h07, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 2'd1, 32'h0000_003F, 6'h07};
        tbl[1]  = '{6'h07, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 2'd3, 32'h0000_0040, 6'h07};
        tbl[2]  = '{6'h00, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 2'd0, 32'h0000_0000, 6'h00};
        tbl[3]  = '{6'h00, 1'b1, 2'd2, 32'h0000_0004, 1'b0, 2'd2, 32'h0000_0004, 6'h00};
        tbl[4]  = '{6'h04, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 2'd0, 32'h0000_0004, 6'h04};
        tbl[5]  = '{6'h00, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 2'd0, 32'h0000_0004, 6'h04};
        tbl[6]  = '{6'h00, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 2'd3, 32'h0000_0042, 6'h04};
        tbl[7]  = '{6'h00, 1'b1, 2'd0, 32'h0000_0004, 1'b0, 2'd0, 32'h0000_0000, 6'h00};
        tbl[8]  = '{6'h02, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 2'd0, 32'h0000_0002, 6'h02};
        tbl[9]  = '{6'h02, 1'b1, 2'd0, 32'h0000_0002, 1'b0, 2'd0, 32'h0000_0002, 6'h02};
        tbl[10] = '{6'h02, 1'b0, 2'd0, 32'h0000_0000, 1'b1, 2'd0, 32'h0000_0002, 6'h02};
        tbl[11] = '{6'h00, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 2'd0, 32'h0000_0000, 6'h00};
        tbl[12] = '{6'h00, 1'b1, 2'd2, 32'h0000_003F, 1'b0, 2'd2, 32'h0000_003F, 6'h00};
        tbl[13] = '{6'h12, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 2'd3, 32'h0000_0041, 6'h12};
        tbl[14] = '{6'h00, 1'b0, 2'd0, 32'h0000_0000, 1'b1, 2'd0, 32'h0000_0010, 6'h10};
        tbl[15] = '{6'h00, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 2'd3, 32'h0000_0044, 6'h10};
        tbl[16] = '{6'h00, 1'b1, 2'd0, 32'h0000_0010, 1'b0, 2'd3, 32'h0000_0000, 6'h00};
        tbl[17] = '{6'h01, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 2'd0, 32'h0000_0001, 6'h01};
        tbl[18] = '{6'h00, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 2'd0, 32'h0000_0001, 6'h01};
        tbl[19] = '{6'h01, 1'b1, 2'd0, 32'h0000_0001, 1'b0, 2'd0, 32'h0000_0001, 6'h01};
        tbl[20] = '{6'h01, 1'b1, 2'd0, 32'h0000_0001, 1'b0, 2'd0, 32'h0000_0000, 6'h00};
        tbl[21] = '{6'h00, 1'b1, 2'd1, 32'h0000_0000, 1'b0, 2'd1, 32'h0000_0000, 6'h00};
        tbl[22] = '{6'h01, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 2'd0, 32'h0000_0001, 6'h00};
        tbl[23] = '{6'h00, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 2'd3, 32'h0000_0000, 6'h00};
        tbl[24] = '{6'h00, 1'b1, 2'd1, 32'h0000_0001, 1'b0, 2'd1, 32'h0000_0001, 6'h01};
        tbl[25] = '{6'h00, 1'b1, 2'd1, 32'hFFFF_FF3F, 1'b0, 2'd1, 32'h0000_003F, 6'h01};
        tbl[26] = '{6'h00, 1'b1, 2'd3, 32'h0000_00FF, 1'b0, 2'd3, 32'h0000_0040, 6'h01};
        tbl[27] = '{6'h3F, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 2'd0, 32'h0000_003F, 6'h3F};
        // after a mid-operation reset: mode back to level, sources held high
        tbl[28] = '{6'h3F, 1'b1, 2'd2, 32'h0000_003F, 1'b0, 2'd0, 32'h0000_003F, 6'h3F};
        tbl[29] = '{6'h3F, 1'b1, 2'd0, 32'h0000_003F, 1'b0, 2'd0, 32'h0000_0000, 6'h00};
        tbl[30] = '{6'h3F, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 2'd0, 32'h0000_0000, 6'h00};
        tbl[31] = '{6'h00, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 2'd0, 32'h0000_0000, 6'h00};
        tbl[32] = '{6'h08, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 2'd0, 32'h0000_0008, 6'h08};
        tbl[33] = '{6'h08, 1'b1, 2'd2, 32'h0000_0000, 1'b0, 2'd2, 32'h0000_0000, 6'h08};
        tbl[34] = '{6'h00, 1'b0, 2'd0, 32'h0000_0000, 1'b0, 2'd0, 32'h0000_0000, 6'h00};

        // Reset held with level sources active: nothing reaches HWInt.
        reset   = 1'b0;
        irq_src = 6'h07;
        WE      = 1'b0;
        Din     = 32'h0;
        int_ack = 1'b0;
        Addr    = {28'h0, 2'd1, 2'b00};
        repeat (2) @(posedge clk);
        #2;
        check_outs("in_reset", 32'h0000_003F, 6'h00);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if (i == 28) begin
                // Assert reset between edges while everything is pending.
                Addr  = {28'h0, 2'd0, 2'b00};
                reset = 1'b0;
                #1;
                check_outs("async_rst pend", 32'h0000_0000, 6'h00);
                Addr = {28'h0, 2'd2, 2'b00};
                #1;
                check32("async_rst mode", Dout, 32'h0000_0000);
                @(negedge clk);
                @(negedge clk);
                check32("async_rst hold", {26'b0, HWInt}, 32'h0000_0000);
                irq_src = 6'h3F;
                reset   = 1'b1;
            end
            run_vec(i, tbl[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
